// File: rtl/data_memory_responder.sv
// Data-memory responder for the load/store unit: one request at a time,
// programmable wait, RV32 byte/half/word access. Optional DMEM_STATS_EN.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_f3;

    logic        a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [2:0]  a_f3;

    logic [31:0] mem [DEPTH_WORDS];

    logic          enter_resp;
    logic          bad_f3;
    logic          misalign;
    logic          oob;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;
    logic [31:0]   wr_word;

    // Access operands: live inputs when entering RESP straight from IDLE
    always_comb begin
        if (state == IDLE) begin
            a_write = req_write;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_f3    = req_funct3;
        end else begin
            a_write = lat_write;
            a_addr  = lat_addr;
            a_wdata = lat_wdata;
            a_f3    = lat_f3;
        end
    end

    // Error check, load extraction and store merge for the current access
    always_comb begin
        enter_resp = ((state == IDLE) && req_valid && (LATENCY == 0))
                   || ((state == BUSY) && (cnt == '0));
        idx      = a_addr[AW+1:2];
        lane     = a_addr[1:0];
        oob      = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
        bad_f3   = a_write ? (a_f3 != 3'b000 && a_f3 != 3'b001 && a_f3 != 3'b010)
                           : (a_f3 == 3'b011 || a_f3 == 3'b110 || a_f3 == 3'b111);
        misalign = ((a_f3[1:0] == 2'b01) && a_addr[0])
                 || ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
        acc_err  = bad_f3 | misalign | oob;
        word     = mem[idx];
        ld_byte  = word[8*lane +: 8];
        ld_half  = a_addr[1] ? word[31:16] : word[15:0];
        case (a_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = word;
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
        wr_word = word;
        case (a_f3[1:0])
            2'b00:   wr_word[8*lane +: 8] = a_wdata[7:0];
            2'b01:   wr_word[16*a_addr[1] +: 16] = a_wdata[15:0];
            default: wr_word = a_wdata;
        endcase
    end

    // Array write on RESP entry; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && a_write && !acc_err) begin
            mem[idx] <= wr_word;
        end
    end

    // Handshake FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_f3     <= 3'b000;
`ifdef DMEM_STATS_EN
            load_count  <= 32'h0;
            store_count <= 32'h0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_f3    <= req_funct3;
                        req_ready <= 1'b0;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY == 0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || a_write) ? 32'h0 : ld_data;
`ifdef DMEM_STATS_EN
                if (!acc_err && a_write)  store_count <= store_count + 1'b1;
                if (!acc_err && !a_write) load_count  <= load_count + 1'b1;
`endif
            end
        end
    end

endmodule
